axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave backed by a 32-bit word SRAM.
// Independent read/write FSMs with per-beat range and protocol checking.
module axi_sram_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter int unsigned           MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1c00_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'd2) || (burst == 2'b11) || (burst == 2'b10 && !wrap_ok);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = a + ADDR_WIDTH'(4);
        mask = ADDR_WIDTH'({len, 2'b11});
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d, bresp_q, bresp_d;
    logic                  wdec_q, wdec_d, wslv_q, wslv_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d, rok_q, rok_d;

    logic [ADDR_WIDTH-1:0] w_off, r_off;
    logic [IDX_W-1:0]      widx, ridx;
    logic                  w_in, r_in, w_last_beat, w_beat_slv, we, rd_en, r_issue;
    logic [1:0]            r_beat_resp;
    logic [31:0]           mem [MEM_WORDS];
    logic [31:0]           mem_rd_q;

    assign w_off       = waddr_q - BASE_ADDR;
    assign w_in        = w_off < MEM_BYTES;
    assign widx        = w_off[IDX_W+1:2];
    assign w_last_beat = wbeat_q == wlen_q;
    assign w_beat_slv  = bad_req(wsize_q, wburst_q, wlen_q) || (wlast != w_last_beat);

    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wbeat_d   = wbeat_q;
        wdec_d    = wdec_q;
        wslv_d    = wslv_q;
        bresp_d   = bresp_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        we        = 1'b0;
        case (w_state_q)
            W_IDLE: if (awvalid && awready_q) begin
                wid_d     = awid;
                waddr_d   = awaddr;
                wlen_d    = awlen;
                wsize_d   = awsize;
                wburst_d  = awburst;
                wbeat_d   = 8'd0;
                wdec_d    = 1'b0;
                wslv_d    = 1'b0;
                awready_d = 1'b0;
                wready_d  = 1'b1;
                w_state_d = W_DATA;
            end
            W_DATA: if (wvalid && wready_q) begin
                wdec_d  = wdec_q | ~w_in;
                wslv_d  = wslv_q | w_beat_slv;
                // Once any beat has failed, later beats must not touch memory.
                we      = w_in && !w_beat_slv && !wdec_q && !wslv_q;
                waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                wbeat_d = wbeat_q + 8'd1;
                if (w_last_beat) begin
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wdec_d ? 2'b11 : (wslv_d ? 2'b10 : 2'b00);
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (bready) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign r_off       = raddr_q - BASE_ADDR;
    assign r_in        = r_off < MEM_BYTES;
    assign ridx        = r_off[IDX_W+1:2];
    assign r_beat_resp = !r_in ? 2'b11 :
                         (bad_req(rsize_q, rburst_q, rlen_q) ? 2'b10 : 2'b00);

    // The array read register doubles as the prefetch stage: the next beat is
    // fetched on the same edge the current one is accepted, so no bubbles.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rok_d     = rok_q;
        rvalid_d  = rvalid_q;
        arready_d = arready_q;
        r_issue   = 1'b0;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: if (arvalid && arready_q) begin
                rid_d     = arid;
                raddr_d   = araddr;
                rlen_d    = arlen;
                rsize_d   = arsize;
                rburst_d  = arburst;
                rbeat_d   = 8'd0;
                arready_d = 1'b0;
                r_state_d = R_FETCH;
            end
            R_FETCH: r_issue = 1'b1;
            R_DATA: if (rready) begin
                if (rlast_q) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    rresp_d   = 2'b00;
                    rok_d     = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end else begin
                    r_issue = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_issue) begin
            rd_en     = r_beat_resp == 2'b00;
            rvalid_d  = 1'b1;
            rlast_d   = rbeat_q == rlen_q;
            rresp_d   = r_beat_resp;
            rok_d     = r_beat_resp == 2'b00;
            raddr_d   = next_addr(raddr_q, rlen_q, rburst_q);
            rbeat_d   = rbeat_q + 8'd1;
            r_state_d = R_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_en) mem_rd_q <= mem[ridx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            wdec_q    <= 1'b0;
            wslv_q    <= 1'b0;
            bresp_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rok_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            wdec_q    <= wdec_d;
            wslv_q    <= wslv_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rok_q     <= rok_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = wid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rdata   = rok_q ? mem_rd_q : 32'h0;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: one task per scenario,
// hand-computed expectations compared inline.
module tb_axi_sram_slave;
    localparam logic [31:0] BASE = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awid = '0, bid, arid = '0, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic        rlast, rvalid, rready = 1'b0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] wbuf [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    int          rd_n, rd_first, rd_span, rd_stall;

    always #5 clk = ~clk;

    axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] strb,
                             input int early);
        int n;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb;
            wlast = (b == int'(len)) || (b == early);
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (bvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL write_bvalid_timeout: got %b want 1", bvalid);
        end
        b_resp = bresp; b_id = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input bit tog);
        int n;
        bit done, hold;
        logic [31:0] h_data;
        logic [1:0]  h_resp;
        logic        h_last;
        logic [3:0]  h_id;
        rd_n = 0; rd_first = -1; rd_span = -1; rd_stall = 0;
        done = 1'b0; hold = 1'b0;
        h_data = '0; h_resp = '0; h_last = 1'b0; h_id = '0;
        @(negedge clk);
        rready = !tog;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        for (int c = 1; c < 200 && !done; c++) begin
            rready = tog ? !rready : 1'b1;
            if (rvalid) begin
                if (rd_first < 0) rd_first = c;
                if (hold && {rdata, rresp, rlast, rid} !== {h_data, h_resp, h_last, h_id})
                    rd_stall++;
                hold = !rready;
                {h_data, h_resp, h_last, h_id} = {rdata, rresp, rlast, rid};
                if (rready) begin
                    if (rd_n < 16) begin
                        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast;
                    end
                    rd_n++;
                    rd_id = rid;
                    if (rlast) begin done = 1'b1; rd_span = c - rd_first; end
                end
            end
            if (!done) @(negedge clk);
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL read_rlast_timeout: got beats=%0d want %0d", rd_n, int'(len) + 1);
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 110000",
                     {awready, arready, wready, bvalid, rvalid, rlast});
        end
        vectors++;
        if ({bresp, rresp, bid, rid} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_resp_id: got %h want 000", {bresp, rresp, bid, rid});
        end
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h want 00000000", rdata);
        end
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF;
        axi_write(4'h5, BASE + 32'h10, 8'd0, 2'b01, 3'd2, 4'hF, -1);
        vectors++;
        if ({b_resp, b_id} !== {2'b00, 4'h5}) begin
            miscompares++;
            $display("FAIL single_bresp_bid: got %b/%h want 00/5", b_resp, b_id);
        end
        axi_read(4'h9, BASE + 32'h10, 8'd0, 2'b01, 1'b0);
        vectors++;
        if (rd_first !== 2) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want 2", rd_first);
        end
        vectors++;
        if ({rd_data[0], rd_resp[0], rd_last[0], rd_id} !== {32'hDEADBEEF, 2'b00, 1'b1, 4'h9}) begin
            miscompares++;
            $display("FAIL single_rbeat: got %h/%b/%b/%h want deadbeef/00/1/9",
                     rd_data[0], rd_resp[0], rd_last[0], rd_id);
        end
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'h11223344;
        axi_write(4'h1, BASE + 32'h20, 8'd0, 2'b01, 3'd2, 4'hF, -1);
        wbuf[0] = 32'hAABBCCDD;
        axi_write(4'h1, BASE + 32'h20, 8'd0, 2'b01, 3'd2, 4'b0101, -1);
        axi_read(4'h2, BASE + 32'h20, 8'd0, 2'b01, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL strobe_merge: got %h want 11bb33dd", rd_data[0]);
        end
    endtask

    task automatic test_incr8();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA000_0000 + 32'(i) * 32'h111;
        axi_write(4'h3, BASE + 32'h100, 8'd7, 2'b01, 3'd2, 4'hF, -1);
        vectors++;
        if (b_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL incr8_bresp: got %b want 00", b_resp);
        end
        axi_read(4'h4, BASE + 32'h100, 8'd7, 2'b01, 1'b0);
        vectors++;
        if (rd_n !== 8 || rd_span !== 7) begin
            miscompares++;
            $display("FAIL incr8_streaming: got beats=%0d span=%0d want 8/7", rd_n, rd_span);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({rd_data[i], rd_last[i]} !== {32'hA000_0000 + 32'(i) * 32'h111, i == 7}) begin
                miscompares++;
                $display("FAIL incr8_beat%0d: got %h/%b want %h/%b", i, rd_data[i],
                         rd_last[i], 32'hA000_0000 + 32'(i) * 32'h111, i == 7);
            end
        end
        axi_read(4'h4, BASE + 32'h100, 8'd7, 2'b01, 1'b1);
        vectors++;
        if (rd_n !== 8 || rd_stall !== 0) begin
            miscompares++;
            $display("FAIL incr8_stall_hold: got beats=%0d unstable=%0d want 8/0", rd_n, rd_stall);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd_data[i] !== 32'hA000_0000 + 32'(i) * 32'h111) begin
                miscompares++;
                $display("FAIL incr8_tog_beat%0d: got %h want %h", i, rd_data[i],
                         32'hA000_0000 + 32'(i) * 32'h111);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC000_0000 + 32'(i);
        axi_write(4'h6, BASE + 32'h18, 8'd3, 2'b10, 3'd2, 4'hF, -1);
        vectors++;
        if (b_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL wrap_bresp: got %b want 00", b_resp);
        end
        exp = '{32'hC000_0002, 32'hC000_0003, 32'hC000_0000, 32'hC000_0001};
        axi_read(4'h6, BASE + 32'h10, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rd_data[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL wrap_layout%0d: got %h want %h", i, rd_data[i], exp[i]);
            end
        end
        axi_read(4'h6, BASE + 32'h18, 8'd3, 2'b10, 1'b0);
        vectors++;
        if ({rd_data[2], rd_data[3]} !== {32'hC000_0002, 32'hC000_0003}) begin
            miscompares++;
            $display("FAIL wrap_read: got %h %h want c0000002 c0000003", rd_data[2], rd_data[3]);
        end
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hD000_0000 + 32'(i);
        axi_write(4'h7, BASE + 32'h40, 8'd3, 2'b01, 3'd2, 4'hF, -1);
        for (int i = 0; i < 3; i++) wbuf[i] = 32'hE000_0000 + 32'(i);
        axi_write(4'h7, BASE + 32'h40, 8'd2, 2'b10, 3'd2, 4'hF, -1);
        vectors++;
        if (b_resp !== 2'b10) begin
            miscompares++;
            $display("FAIL wrap_len2_bresp: got %b want 10", b_resp);
        end
        axi_read(4'h7, BASE + 32'h40, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rd_data[i] !== 32'hD000_0000 + 32'(i)) begin
                miscompares++;
                $display("FAIL wrap_len2_unchanged%0d: got %h want %h", i, rd_data[i],
                         32'hD000_0000 + 32'(i));
            end
        end
        axi_read(4'h7, BASE + 32'h40, 8'd2, 2'b10, 1'b0);
        vectors++;
        if ({rd_resp[0], rd_data[0], rd_n} !== {2'b10, 32'h0, 32'd3}) begin
            miscompares++;
            $display("FAIL wrap_len2_rresp: got %b/%h/%0d want 10/00000000/3",
                     rd_resp[0], rd_data[0], rd_n);
        end
    endtask

    task automatic test_errors();
        axi_read(4'hA, BASE + 32'h4000, 8'd1, 2'b01, 1'b0);
        vectors++;
        if ({rd_n, rd_resp[0], rd_resp[1], rd_data[0], rd_data[1], rd_last[0], rd_last[1]}
            !== {32'd2, 2'b11, 2'b11, 32'h0, 32'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL oob_read: got n=%0d %b %b %h %h want 2 11 11 0 0",
                     rd_n, rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]);
        end
        wbuf[0] = 32'h5A5A_0001;
        axi_write(4'hB, BASE + 32'h3FFC, 8'd0, 2'b01, 3'd2, 4'hF, -1);
        axi_read(4'hB, BASE + 32'h3FFC, 8'd1, 2'b01, 1'b0);
        vectors++;
        if ({rd_resp[0], rd_data[0], rd_resp[1], rd_data[1]}
            !== {2'b00, 32'h5A5A_0001, 2'b11, 32'h0}) begin
            miscompares++;
            $display("FAIL top_edge_read: got %b/%h %b/%h want 00/5a5a0001 11/0",
                     rd_resp[0], rd_data[0], rd_resp[1], rd_data[1]);
        end
        wbuf[0] = 32'h1; wbuf[1] = 32'h2;
        axi_write(4'hC, BASE + 32'h50, 8'd1, 2'b01, 3'd2, 4'hF, 0);
        vectors++;
        if ({b_resp, b_id} !== {2'b10, 4'hC}) begin
            miscompares++;
            $display("FAIL early_wlast: got %b/%h want 10/c", b_resp, b_id);
        end
        axi_write(4'hD, BASE - 32'h4, 8'd0, 2'b01, 3'd2, 4'hF, -1);
        vectors++;
        if (b_resp !== 2'b11) begin
            miscompares++;
            $display("FAIL below_base_write: got %b want 11", b_resp);
        end
        axi_write(4'hE, BASE + 32'h60, 8'd0, 2'b01, 3'd1, 4'hF, -1);
        vectors++;
        if (b_resp !== 2'b10) begin
            miscompares++;
            $display("FAIL bad_size_write: got %b want 10", b_resp);
        end
    endtask

    task automatic test_same_cycle();
        int n;
        wbuf[0] = 32'h0101_0101;
        axi_write(4'h1, BASE + 32'h30, 8'd0, 2'b01, 3'd2, 4'hF, -1);
        @(negedge clk);
        awid = 4'h2; awaddr = BASE + 32'h30; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 1'b0;
        arid = 4'h3; araddr = BASE + 32'h30; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1; rready = 1'b1;
        vectors++;
        if ({arready, wready} !== 2'b11) begin
            miscompares++;
            $display("FAIL collide_setup: got arready/wready=%b want 11", {arready, wready});
        end
        @(negedge clk);
        arvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h0202_0202; wstrb = 4'hF; wlast = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        vectors++;
        if ({rvalid, rdata} !== {1'b1, 32'h0101_0101}) begin
            miscompares++;
            $display("FAIL collide_old_data: got %b/%h want 1/01010101", rvalid, rdata);
        end
        vectors++;
        if ({bvalid, bresp, bid} !== {1'b1, 2'b00, 4'h2}) begin
            miscompares++;
            $display("FAIL collide_bresp: got %b/%b/%h want 1/00/2", bvalid, bresp, bid);
        end
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        axi_read(4'h3, BASE + 32'h30, 8'd0, 2'b01, 1'b0);
        vectors++;
        if (rd_data[0] !== 32'h0202_0202) begin
            miscompares++;
            $display("FAIL collide_new_data: got %h want 02020202", rd_data[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int  n;
        int  beats;
        bit  hit;
        @(negedge clk);
        rready = 1'b1;
        arid = 4'h8; araddr = BASE + 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        beats = 0; hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (rvalid) begin
                if (beats == 3) begin
                    rst = 1'b1;
                    #1;
                    hit = 1'b1;
                end else begin
                    beats++;
                end
            end
            if (!hit) @(negedge clk);
        end
        vectors++;
        if ({hit, rvalid, arready, rdata} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_mid_read: got hit=%b rvalid=%b arready=%b rdata=%h want 1/0/1/0",
                     hit, rvalid, arready, rdata);
        end
        @(negedge clk);
        rst = 1'b0; rready = 1'b0;
        axi_read(4'h9, BASE + 32'h100, 8'd1, 2'b01, 1'b0);
        vectors++;
        if ({rd_n, rd_data[0], rd_data[1], rd_resp[1], rd_last[1], rd_id}
            !== {32'd2, 32'hA000_0000, 32'hA000_0111, 2'b00, 1'b1, 4'h9}) begin
            miscompares++;
            $display("FAIL read_after_reset: got n=%0d %h %h %b %b %h want 2 a0000000 a0000111 00 1 9",
                     rd_n, rd_data[0], rd_data[1], rd_resp[1], rd_last[1], rd_id);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single();
        test_strobe();
        test_incr8();
        test_wrap();
        test_errors();
        test_same_cycle();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
